// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the core's fetch/data ports, the unified memory and the
// pipeline stall lines. slave = arbiter side, master = core/memory side.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall_f;
  logic              stall_m;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ready, d_rdata, d_ready,
           mem_en, mem_we, mem_addr, mem_wdata, stall_f, stall_m
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ready, d_rdata, d_ready,
           mem_en, mem_we, mem_addr, mem_wdata, stall_f, stall_m
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Serialises IF-stage fetches and MEM-stage loads/stores onto one fixed-latency
// memory port; data has priority, with a fetch anti-starvation counter.
module unified_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  unified_mem_arbiter_if.slave  bus
);

  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam int LW = $clog2(MEM_LAT + 1);

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state, stateNext;
  logic [SW-1:0] starveCnt;
  logic [LW-1:0] latCnt;
  logic          grantData;

  logic          anyReq;
  logic          starved;
  logic          pickData;
  logic          lastBeat;
  addr_t         nextAddr;
  data_t         nextWdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    anyReq    = bus.if_req | bus.d_req;
    starved   = (STARVE_MAX != 0) && (starveCnt == SW'(STARVE_MAX));
    // data wins a tie unless fetch has lost STARVE_MAX times in a row
    pickData  = bus.d_req && !(bus.if_req && starved);
    lastBeat  = (latCnt == LW'(1));
    nextAddr  = pickData ? bus.d_addr : bus.if_addr;
    nextWdata = pickData ? bus.d_wdata : '0;
    stateNext = state;
    case (state)
      IDLE:    if (anyReq)   stateNext = ISSUE;
      ISSUE:                 stateNext = WAIT;
      WAIT:    if (lastBeat) stateNext = RESP;
      RESP:                  stateNext = IDLE;
      default:               stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starveCnt     <= '0;
      latCnt        <= '0;
      grantData     <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_rdata  <= '0;
      bus.d_rdata   <= '0;
      bus.if_ready  <= 1'b0;
      bus.d_ready   <= 1'b0;
    end else begin
      bus.mem_en   <= 1'b0;
      bus.if_ready <= 1'b0;
      bus.d_ready  <= 1'b0;
      case (state)
        IDLE: begin
          if (anyReq) begin
            grantData     <= pickData;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= pickData & bus.d_we;
            bus.mem_addr  <= nextAddr;
            bus.mem_wdata <= nextWdata;
            if (!pickData)
              starveCnt <= '0;
            else if (bus.if_req && (starveCnt != SW'(STARVE_MAX)))
              starveCnt <= starveCnt + SW'(1);
          end
        end
        ISSUE: latCnt <= LW'(MEM_LAT);
        WAIT: begin
          latCnt <= latCnt - LW'(1);
          // capture on the edge where mem_rdata is valid; ready shows in RESP
          if (lastBeat) begin
            if (grantData) begin
              bus.d_ready <= 1'b1;
              if (!bus.mem_we) bus.d_rdata <= bus.mem_rdata;
            end else begin
              bus.if_ready <= 1'b1;
              bus.if_rdata <= bus.mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.stall_f = bus.if_req & ~bus.if_ready;
  assign bus.stall_m = bus.d_req  & ~bus.d_ready;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: requester tasks push expected
// responses, a negedge monitor checks grants, timing and returned data.
module tb_unified_mem_arbiter;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  unified_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] initWord(input int i);
    if (i == 4)  return 32'h0050_0093;
    if (i == 16) return 32'h1234_5678;
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // ---------------- memory model (environment) ----------------
  logic [31:0] memArr [256];
  bit          memInit = 1'b0;
  logic [31:0] rdD [MEM_LAT];
  logic        rdV [MEM_LAT];
  logic [31:0] junk;

  always @(posedge clk) begin
    junk <= $urandom;
    if (!memInit) begin
      for (int i = 0; i < 256; i++) memArr[i] <= initWord(i);
      memInit <= 1'b1;
    end else if (bus.mem_en && bus.mem_we) begin
      memArr[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end
    rdV[0] <= bus.mem_en && !bus.mem_we;
    rdD[0] <= memArr[bus.mem_addr[9:2]];
    for (int i = 1; i < MEM_LAT; i++) begin
      rdV[i] <= rdV[i-1];
      rdD[i] <= rdD[i-1];
    end
  end

  assign bus.mem_rdata = (rdV[MEM_LAT-1] === 1'b1) ? rdD[MEM_LAT-1] : junk;

  // ---------------- reference state ----------------
  logic [31:0] shadow [256];
  logic [31:0] lastD;
  logic [31:0] ifExpQ[$];
  logic [31:0] dExpQ[$];
  bit          grantLog[$];

  // ---------------- monitor / transaction model ----------------
  int          cyc = 0;
  bit          pendIss = 0, inFl = 0, expData = 0, expWe = 0;
  int          issCyc = 0, respCyc = -1, losses = 0;
  logic [31:0] expAddr, expWd, popped;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      pendIss = 0;
      inFl    = 0;
      losses  = 0;
    end else begin
      chk("stall_f", 32'(bus.stall_f), 32'(bus.if_req & ~bus.if_ready));
      chk("stall_m", 32'(bus.stall_m), 32'(bus.d_req & ~bus.d_ready));

      if (pendIss) begin
        chk("mem_en_issue", 32'(bus.mem_en), 1);
        chk("mem_addr", bus.mem_addr, expAddr);
        chk("mem_we", 32'(bus.mem_we), 32'(expWe));
        if (expWe) chk("mem_wdata", bus.mem_wdata, expWd);
        grantLog.push_back(bus.mem_addr[8]);
        pendIss = 0;
        inFl    = 1;
        issCyc  = cyc;
      end else begin
        chk("mem_en_quiet", 32'(bus.mem_en), 0);
      end

      if (inFl && cyc == issCyc + 1 + MEM_LAT) begin
        if (expData) begin
          chk("d_ready", 32'(bus.d_ready), 1);
          chk("if_ready_other", 32'(bus.if_ready), 0);
          chk("d_exp_queue", 32'(dExpQ.size() > 0), 1);
          if (dExpQ.size() > 0) begin
            popped = dExpQ.pop_front();
            chk("d_rdata", bus.d_rdata, popped);
          end
        end else begin
          chk("if_ready", 32'(bus.if_ready), 1);
          chk("d_ready_other", 32'(bus.d_ready), 0);
          chk("if_exp_queue", 32'(ifExpQ.size() > 0), 1);
          if (ifExpQ.size() > 0) begin
            popped = ifExpQ.pop_front();
            chk("if_rdata", bus.if_rdata, popped);
          end
        end
        inFl    = 0;
        respCyc = cyc;
      end else begin
        chk("if_ready_quiet", 32'(bus.if_ready), 0);
        chk("d_ready_quiet", 32'(bus.d_ready), 0);
      end

      // arbiter is free from the cycle after a ready pulse; decide from the rules
      if (!pendIss && !inFl && cyc != respCyc && (bus.if_req || bus.d_req)) begin
        if (bus.if_req && bus.d_req)
          expData = !(STARVE_MAX != 0 && losses == STARVE_MAX);
        else
          expData = bus.d_req;
        if (expData) begin
          if (bus.if_req && losses < STARVE_MAX) losses++;
          expAddr = bus.d_addr;
          expWe   = bus.d_we;
          expWd   = bus.d_wdata;
        end else begin
          losses  = 0;
          expAddr = bus.if_addr;
          expWe   = 0;
          expWd   = '0;
        end
        pendIss = 1;
      end
    end
  end

  // ---------------- requester tasks ----------------
  task automatic fetchTxn(input logic [31:0] a, input bit drop);
    bit got = 0;
    bus.if_req  = 1'b1;
    bus.if_addr = a;
    ifExpQ.push_back(shadow[a[9:2]]);
    for (int n = 0; n < 64 && !got; n++) begin
      @(posedge clk); #1;
      if (drop) bus.if_req = 1'b0;
      if (bus.if_ready) got = 1;
    end
    chk("fetch_complete", 32'(got), 1);
    bus.if_req = 1'b0;
  endtask

  task automatic dataTxn(input logic we, input logic [31:0] a, input logic [31:0] wd);
    bit got = 0;
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_addr  = a;
    bus.d_wdata = wd;
    if (we) shadow[a[9:2]] = wd;
    else    lastD = shadow[a[9:2]];
    dExpQ.push_back(lastD);
    for (int n = 0; n < 64 && !got; n++) begin
      @(posedge clk); #1;
      if (bus.d_ready) got = 1;
    end
    chk("data_complete", 32'(got), 1);
    bus.d_req = 1'b0;
  endtask

  task automatic resetOutputsCheck(input string tag);
    chk({tag, "_mem_en"},    32'(bus.mem_en), 0);
    chk({tag, "_mem_we"},    32'(bus.mem_we), 0);
    chk({tag, "_mem_addr"},  bus.mem_addr, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_if_rdata"},  bus.if_rdata, 0);
    chk({tag, "_d_rdata"},   bus.d_rdata, 0);
    chk({tag, "_if_ready"},  32'(bus.if_ready), 0);
    chk({tag, "_d_ready"},   32'(bus.d_ready), 0);
    chk({tag, "_stall_f"},   32'(bus.stall_f), 32'(bus.if_req));
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] ord;

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    for (int i = 0; i < 256; i++) shadow[i] = initWord(i);
    lastD = '0;

    #1 rst = 1'b1;
    #1 resetOutputsCheck("rst_init");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // single fetch, then fetch vs load contention, then store
    fetchTxn(32'h10, 1'b0);
    @(posedge clk); #1;
    fork
      fetchTxn(32'h10, 1'b0);
      dataTxn(1'b0, 32'h40, '0);
    join
    dataTxn(1'b1, 32'h20, 32'hDEAD_BEEF);

    // fetch requester drops its request right after the grant
    @(posedge clk); #1;
    fetchTxn(32'h20, 1'b1);

    // reset while a store waits for its latency to run out
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h120; bus.d_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    #1 resetOutputsCheck("rst_wait");
    shadow[32'h120 >> 2] = 32'hCAFE_F00D;
    lastD = '0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk); #1;
    fetchTxn(32'h0, 1'b0);
    dataTxn(1'b0, 32'h120, '0);

    // both ports held continuously: starvation counter forces every third grant
    @(posedge clk); #1;
    grantLog.delete();
    fork
      begin
        fetchTxn(32'h0, 1'b0);
        fetchTxn(32'h4, 1'b0);
      end
      begin
        for (int k = 0; k < 4; k++) dataTxn(1'b0, 32'h100 + 32'(4 * k), '0);
      end
    join
    chk("grant_count", 32'(grantLog.size()), 6);
    ord = '0;
    foreach (grantLog[i]) ord = {ord[30:0], grantLog[i]};
    chk("grant_order", ord, 32'b110110);

    // randomized concurrent traffic; fetch and data use disjoint address ranges
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          fetchTxn(32'($urandom_range(0, 63)) << 2, 1'b0);
        end
      end
      begin
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          dataTxn(1'($urandom_range(0, 1)), 32'($urandom_range(64, 255)) << 2, $urandom);
        end
      end
    join
    repeat (10) @(posedge clk); #1;
    chk("if_queue_drained", 32'(ifExpQ.size()), 0);
    chk("d_queue_drained", 32'(dExpQ.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between the core's instruction-fetch port (IF stage) and data port (MEM stage).
- Serialises accesses with a request/ready handshake and a small FSM.
- Produces per-port stall signals that the pipeline uses to freeze the IF and MEM stages.
- Default policy is data-priority, with a fetch anti-starvation counter.

Parameters:
ADDR_W, 32, address width of both ports and the memory
DATA_W, 32, data width
MEM_LAT, 2, cycles from the mem_en cycle to valid mem_rdata (>=1)
STARVE_MAX, 3, consecutive fetch losses before fetch is forced to win (0 = pure data priority)

Ports:
clk  in  1  clock
rst  in  1  reset
if_req  in  1  fetch request, held until if_ready
if_addr  in  ADDR_W  fetch address, stable while if_req
if_rdata  out  DATA_W  fetched instruction, valid when if_ready
if_ready  out  1  one-cycle fetch completion pulse
d_req  in  1  data request, held until d_ready
d_we  in  1  1 = write, 0 = read
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data, valid when d_ready
d_ready  out  1  one-cycle data completion pulse
mem_en  out  1  memory strobe, exactly one cycle per access
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
stall_f  out  1  freeze IF stage
stall_m  out  1  freeze MEM stage

Behaviour:
- Reset: rst is asynchronous, active-high; clk is the clock.
- Reset values:
  - state IDLE, starvation counter 0, latency counter 0.
  - mem_en/mem_we 0; mem_addr/mem_wdata 0.
  - if_rdata/d_rdata 0; if_ready/d_ready 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: requests are sampled only here. On a clock edge with any req, register the grantee (G) and move to ISSUE, loading:
  - mem_addr from G's address.
  - mem_we = d_we for data, 0 for fetch.
  - mem_wdata.
- Arbitration when both requests are present:
  - Data wins, unless the starvation counter == STARVE_MAX (and STARVE_MAX != 0); then fetch wins.
  - Counter increments on each edge where data wins while if_req is high.
  - Counter clears whenever fetch is granted.
  - Counter saturates at STARVE_MAX.
- ISSUE: mem_en = 1 for this cycle only; latency counter loads MEM_LAT; go to WAIT.
- WAIT: counter decrements each cycle. When it reaches 1, capture mem_rdata on that edge into G's rdata (reads only) and assert G's ready; go to RESP.
  - Writes do not update d_rdata; d_rdata holds its prior value.
- RESP: G's ready is high for exactly this cycle; return to IDLE. The requester uses this cycle to drop or change its request. No sampling happens in RESP, so there is no double issue.
- Timing: req at cycle 0 (in IDLE) → mem_en at cycle 1 → mem_rdata valid at cycle 1+MEM_LAT → ready at cycle 2+MEM_LAT. The earliest next issue decision is at the end of cycle 3+MEM_LAT.
- mem_addr/mem_we/mem_wdata hold their values until the next grant.
- Stalls (combinational):
  - stall_f = if_req & ~if_ready.
  - stall_m = d_req & ~d_ready.
  - A ready pulse releases the stall in the same cycle.
- Requester drops req after grant: the access completes and the ready pulse is still issued; the arbiter does not cancel.
- Only one access is in flight at a time; there is no pipelining of memory requests.
- Reset mid-operation:
  - Asynchronously returns to IDLE; mem_en drops immediately.
  - No ready pulse is issued for the abandoned access.
  - A write is committed only if its ISSUE cycle completed before rst.
- Both ports share the same address space; this block does no address decoding.

Test Plan:
- Reset check: assert rst mid-stream → all outputs listed above read 0 on the same cycle; stall_f equals if_req.
- Single fetch, MEM_LAT=2: if_req=1, if_addr=0x10 at cycle 0; memory returns 0x00500093 → mem_en=1, mem_addr=0x10 at cycle 1 only; if_ready=1 with if_rdata=0x00500093 at cycle 4; stall_f high for cycles 0-3.
- Simultaneous requests, STARVE_MAX=0: if_req plus a d_req load from 0x40 (mem data 0x12345678) → data serviced first (d_ready at cycle 4, d_rdata=0x12345678); fetch issued next (mem_en at cycle 6).
- Starvation, STARVE_MAX=2: if_req and d_req both held continuously → grant order D,D,F,D,D,F; counter clears after each F.
- Store: d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF → one mem_en cycle with mem_we=1, mem_addr=0x20, mem_wdata=0xDEADBEEF; d_ready pulses; d_rdata unchanged.
- Reset in WAIT: assert rst the cycle after mem_en → no if_ready/d_ready; a subsequent fetch to 0x0 completes with normal latency.
